// File: rtl/debug_ctrl_pkg.sv
// Shared types for the execution/debug controller: FSM state encoding,
// execution-mode and dump-select constants.
package debug_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_RUN       = 3'd1,
      ST_STEP_WAIT = 3'd2,
      ST_STEP      = 3'd3,
      ST_DUMP_REG  = 3'd4,
      ST_DUMP_MEM  = 3'd5,
      ST_DONE      = 3'd6
   } state_t;

   localparam logic MODE_CONT    = 1'b0;
   localparam logic MODE_STEP    = 1'b1;

   localparam logic DUMP_SEL_REG = 1'b0;
   localparam logic DUMP_SEL_MEM = 1'b1;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/dump_sequencer.sv
// Walks one dump phase (register file or data memory): issues indices, captures
// the read word one cycle later and holds it on a valid/ready port until accepted.
module dump_sequencer #(
   parameter int N_BITS = 32,
   parameter int IW     = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              start,
   input  logic              phase,
   input  logic [IW:0]       len,
   input  logic [N_BITS-1:0] rd_data,
   input  logic              ready,
   output logic [IW-1:0]     idx,
   output logic              sel,
   output logic [N_BITS-1:0] data,
   output logic              valid,
   output logic              phase_done
);

   logic          active;
   logic          wait_rd;
   logic [IW:0]   len_q;
   logic          last;

   assign last       = ({1'b0, idx} == (len_q - (IW+1)'(1)));
   assign phase_done = en & active & valid & ready & last;

   // The index is registered, so the word for it is sampled on the following edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx     <= '0;
         sel     <= 1'b0;
         data    <= '0;
         valid   <= 1'b0;
         active  <= 1'b0;
         wait_rd <= 1'b0;
         len_q   <= '0;
      end else if (en) begin
         if (start) begin
            idx     <= '0;
            sel     <= phase;
            len_q   <= len;
            active  <= 1'b1;
            wait_rd <= 1'b1;
            valid   <= 1'b0;
         end else if (active) begin
            if (wait_rd) begin
               data    <= rd_data;
               valid   <= 1'b1;
               wait_rd <= 1'b0;
            end else if (valid && ready) begin
               valid <= 1'b0;
               if (last) begin
                  active <= 1'b0;
               end else begin
                  idx     <= idx + IW'(1);
                  wait_rd <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: rtl/debug_exec_ctrl.sv
// Execution/debug controller: gates the pipeline (continuous or multi-cycle step),
// counts enabled cycles, and dumps regs then memory after halt. Option: DEBUG_BREAKPOINT_EN.
//
// state        | meaning
// IDLE         | after reset, waiting for clock lock
// RUN          | pipeline enabled every cycle
// STEP_WAIT    | pipeline paused, waiting for a step rising edge
// STEP         | pipeline enabled for the loaded number of cycles
// DUMP_REG     | streaming register file words
// DUMP_MEM     | streaming data memory words
// DONE         | dump finished, everything idle until reset
module debug_exec_ctrl
   import debug_ctrl_pkg::*;
#(
   parameter int N_BITS   = 32,
   parameter int N_REGS   = 32,
   parameter int N_MEM    = 64,
   parameter int CNT_BITS = 8,
   localparam int RB      = $clog2(N_REGS),
   localparam int MB      = $clog2(N_MEM)
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic                i_valid,
   input  logic                i_exec_mode,
   input  logic                i_step,
   input  logic [CNT_BITS-1:0] i_step_count,
   input  logic                i_halt,
   output logic                o_pipe_en,
   output logic [N_BITS-1:0]   o_ciclos,
   output logic                o_halt,
   output logic                o_dump_sel,
   output logic [RB-1:0]       o_n_reg,
   output logic [MB-1:0]       o_mem_addr,
   input  logic [N_BITS-1:0]   i_dump_data,
   output logic [N_BITS-1:0]   o_dump_data,
   output logic                o_dump_valid,
   input  logic                i_dump_ready,
   output logic                o_done
`ifdef DEBUG_BREAKPOINT_EN
   ,
   input  logic [N_BITS-1:0]   i_pc,
   input  logic [N_BITS-1:0]   i_bp_addr,
   input  logic                i_bp_en,
   output logic                o_bp_hit
`endif
);

   localparam int IW = max_int(RB, MB);

   state_t                state, nxt;
   logic                  pipe_en;
   logic                  step_prev;
   logic                  step_edge;
   logic                  bp_stop;
   logic [CNT_BITS-1:0]   remaining;
   logic                  seq_start;
   logic                  seq_phase;
   logic [IW:0]           seq_len;
   logic [IW-1:0]         seq_idx;
   logic                  seq_sel;
   logic                  seq_done;

   assign step_edge = i_step & ~step_prev;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) state <= ST_IDLE;
      else         state <= nxt;
   end

   // Halt has priority over breakpoint, step end and mode change.
   always_comb begin
      nxt = state;
      if (i_valid) begin
         case (state)
            ST_IDLE:      nxt = (i_exec_mode == MODE_STEP) ? ST_STEP_WAIT : ST_RUN;
            ST_RUN: begin
               if (i_halt)                                   nxt = ST_DUMP_REG;
               else if (bp_stop || i_exec_mode == MODE_STEP) nxt = ST_STEP_WAIT;
            end
            ST_STEP_WAIT: begin
               if (i_exec_mode == MODE_CONT) nxt = ST_RUN;
               else if (step_edge)           nxt = ST_STEP;
            end
            ST_STEP: begin
               if (i_halt)                                         nxt = ST_DUMP_REG;
               else if (bp_stop || remaining == CNT_BITS'(1))      nxt = ST_STEP_WAIT;
            end
            ST_DUMP_REG:  if (seq_done) nxt = ST_DUMP_MEM;
            ST_DUMP_MEM:  if (seq_done) nxt = ST_DONE;
            default:      nxt = state;
         endcase
      end
   end

   always_comb begin
      pipe_en   = i_valid && (state == ST_RUN || state == ST_STEP);
      seq_start = 1'b0;
      seq_phase = DUMP_SEL_REG;
      seq_len   = (IW+1)'(N_REGS);
      if (nxt == ST_DUMP_REG && state != ST_DUMP_REG) begin
         seq_start = 1'b1;
      end
      if (nxt == ST_DUMP_MEM && state == ST_DUMP_REG) begin
         seq_start = 1'b1;
         seq_phase = DUMP_SEL_MEM;
         seq_len   = (IW+1)'(N_MEM);
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         o_ciclos  <= '0;
         o_halt    <= 1'b0;
         step_prev <= 1'b0;
         remaining <= '0;
      end else if (i_valid) begin
         step_prev <= i_step;
         if (pipe_en && o_ciclos != '1) o_ciclos <= o_ciclos + N_BITS'(1);
         if (pipe_en && i_halt)         o_halt   <= 1'b1;
         if (state == ST_STEP_WAIT && nxt == ST_STEP)
            remaining <= (i_step_count == '0) ? CNT_BITS'(1) : i_step_count;
         else if (state == ST_STEP)
            remaining <= remaining - CNT_BITS'(1);
      end
   end

`ifdef DEBUG_BREAKPOINT_EN
   logic bp_skip;
   logic bp_hit_q;

   // bp_skip lets execution move off the breakpoint PC after a resume.
   assign bp_stop  = pipe_en & i_bp_en & (i_pc == i_bp_addr) & ~bp_skip;
   assign o_bp_hit = bp_hit_q;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         bp_skip  <= 1'b0;
         bp_hit_q <= 1'b0;
      end else begin
         bp_hit_q <= bp_stop & ~i_halt;
         if (bp_stop && !i_halt) bp_skip <= 1'b1;
         else if (pipe_en)       bp_skip <= 1'b0;
      end
   end
`else
   assign bp_stop = 1'b0;
`endif

   dump_sequencer #(
      .N_BITS (N_BITS),
      .IW     (IW)
   ) u_dump_seq (
      .clk        (i_clk),
      .rst        (i_reset),
      .en         (i_valid),
      .start      (seq_start),
      .phase      (seq_phase),
      .len        (seq_len),
      .rd_data    (i_dump_data),
      .ready      (i_dump_ready),
      .idx        (seq_idx),
      .sel        (seq_sel),
      .data       (o_dump_data),
      .valid      (o_dump_valid),
      .phase_done (seq_done)
   );

   assign o_pipe_en  = pipe_en;
   assign o_done     = (state == ST_DONE);
   assign o_dump_sel = seq_sel;
   assign o_n_reg    = (seq_sel == DUMP_SEL_REG) ? seq_idx[RB-1:0] : '0;
   assign o_mem_addr = (seq_sel == DUMP_SEL_MEM) ? seq_idx[MB-1:0] : '0;

endmodule

// File: tb/tb_debug_exec_ctrl.sv
// Directed bench for debug_exec_ctrl: continuous run, stepping, halt, dump with
// backpressure and asynchronous reset mid-dump.
module tb_debug_exec_ctrl;

   localparam int N_BITS   = 32;
   localparam int N_REGS   = 32;
   localparam int N_MEM    = 64;
   localparam int CNT_BITS = 8;

   logic                i_clk = 1'b0;
   logic                i_reset;
   logic                i_valid;
   logic                i_exec_mode;
   logic                i_step;
   logic [CNT_BITS-1:0] i_step_count;
   logic                i_halt;
   logic                o_pipe_en;
   logic [N_BITS-1:0]   o_ciclos;
   logic                o_halt;
   logic                o_dump_sel;
   logic [4:0]          o_n_reg;
   logic [5:0]          o_mem_addr;
   logic [N_BITS-1:0]   i_dump_data;
   logic [N_BITS-1:0]   o_dump_data;
   logic                o_dump_valid;
   logic                i_dump_ready;
   logic                o_done;
`ifdef DEBUG_BREAKPOINT_EN
   logic [N_BITS-1:0]   i_pc;
   logic [N_BITS-1:0]   i_bp_addr;
   logic                i_bp_en;
   logic                o_bp_hit;
   assign i_pc = o_ciclos << 2;
`endif

   int n_checks = 0;
   int n_errs   = 0;

   always #5 i_clk = ~i_clk;

   function automatic logic [N_BITS-1:0] reg_fn(input int k);
      return 32'hC0DE0000 + 32'(k);
   endfunction

   function automatic logic [N_BITS-1:0] mem_fn(input int a);
      return 32'hBEEF0000 + 32'(a * 3);
   endfunction

   assign i_dump_data = o_dump_sel ? mem_fn(int'(o_mem_addr)) : reg_fn(int'(o_n_reg));

   debug_exec_ctrl #(
      .N_BITS   (N_BITS),
      .N_REGS   (N_REGS),
      .N_MEM    (N_MEM),
      .CNT_BITS (CNT_BITS)
   ) dut (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_valid      (i_valid),
      .i_exec_mode  (i_exec_mode),
      .i_step       (i_step),
      .i_step_count (i_step_count),
      .i_halt       (i_halt),
      .o_pipe_en    (o_pipe_en),
      .o_ciclos     (o_ciclos),
      .o_halt       (o_halt),
      .o_dump_sel   (o_dump_sel),
      .o_n_reg      (o_n_reg),
      .o_mem_addr   (o_mem_addr),
      .i_dump_data  (i_dump_data),
      .o_dump_data  (o_dump_data),
      .o_dump_valid (o_dump_valid),
      .i_dump_ready (i_dump_ready),
      .o_done       (o_done)
`ifdef DEBUG_BREAKPOINT_EN
      ,
      .i_pc         (i_pc),
      .i_bp_addr    (i_bp_addr),
      .i_bp_en      (i_bp_en),
      .o_bp_hit     (o_bp_hit)
`endif
   );

   // Pipeline-enable monitor: enabled cycles and separate enable pulses.
   logic mon_clr = 1'b1;
   int   en_cnt;
   int   pulse_cnt;
   logic en_prev;

   always @(negedge i_clk) begin
      if (mon_clr) begin
         en_cnt    <= 0;
         pulse_cnt <= 0;
         en_prev   <= 1'b0;
      end else begin
         if (o_pipe_en)             en_cnt    <= en_cnt + 1;
         if (o_pipe_en && !en_prev) pulse_cnt <= pulse_cnt + 1;
         en_prev <= o_pipe_en;
      end
   end

   task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic do_reset();
      i_reset      = 1'b1;
      i_valid      = 1'b0;
      i_exec_mode  = 1'b0;
      i_step       = 1'b0;
      i_step_count = CNT_BITS'(1);
      i_halt       = 1'b0;
      i_dump_ready = 1'b0;
`ifdef DEBUG_BREAKPOINT_EN
      i_bp_addr    = '0;
      i_bp_en      = 1'b0;
`endif
      #40;
      chk("reset_outputs", 96'({o_pipe_en, o_ciclos, o_halt, o_dump_sel, o_n_reg, o_mem_addr,
                                o_dump_data, o_dump_valid, o_done}), 96'(0));
      @(negedge i_clk);
      i_reset = 1'b0;
      tick();
   endtask

   // Continuous run; raises i_halt during the n-th enabled cycle.
   task automatic run_to_halt(input int n, input int freeze_at);
      int   cnt   = 0;
      int   cyc   = 0;
      logic froze = 1'b0;
      i_exec_mode = 1'b0;
      i_valid     = 1'b1;
      while (cnt < n && cyc < 1000) begin
         if (cnt == freeze_at && !froze) begin
            froze   = 1'b1;
            i_valid = 1'b0;
            #1;
            chk("freeze_pipe", 96'(o_pipe_en), 96'(0));
            repeat (3) tick();
            chk("freeze_ciclos", 96'(o_ciclos), 96'(freeze_at));
            chk("freeze_pipe_held", 96'(o_pipe_en), 96'(0));
            i_valid = 1'b1;
            #1;
         end
         if (o_pipe_en) begin
            cnt++;
            if (cnt == n) i_halt = 1'b1;
         end
         tick();
         cyc++;
      end
      i_halt = 1'b0;
      chk("run_len", 96'(cnt), 96'(n));
   endtask

   // Drains the whole dump, checking every word; optionally stalls at word stall_k.
   task automatic dump_all(input int stall_k, input int stall_n);
      int          k        = 0;
      int          stalled  = 0;
      int          cyc      = 0;
      logic        acc;
      logic        prev_acc = 1'b0;
      logic [38:0] got, exp;
      while (!o_done && cyc < 1000) begin
         acc = 1'b0;
         if (prev_acc) chk("dump_gap", 96'(o_dump_valid), 96'(0));
         if (o_dump_valid) begin
            if (k < N_REGS) begin
               got = {o_dump_sel, 6'(o_n_reg), o_dump_data};
               exp = {1'b0, 6'(k), reg_fn(k)};
            end else begin
               got = {o_dump_sel, o_mem_addr, o_dump_data};
               exp = {1'b1, 6'(k - N_REGS), mem_fn(k - N_REGS)};
            end
            chk("dump_word", 96'(got), 96'(exp));
            if (k == stall_k && stalled < stall_n) begin
               i_dump_ready = 1'b0;
               stalled++;
            end else begin
               i_dump_ready = 1'b1;
               acc = 1'b1;
            end
         end else begin
            i_dump_ready = 1'b1;
         end
         tick();
         if (acc) k++;
         prev_acc = acc;
         cyc++;
      end
      chk("dump_count", 96'(k), 96'(N_REGS + N_MEM));
      chk("dump_stalls", 96'(stalled), 96'(stall_n));
      chk("dump_done", 96'(o_done), 96'(1));
      chk("dump_valid_off", 96'(o_dump_valid), 96'(0));
      chk("dump_pipe_off", 96'(o_pipe_en), 96'(0));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int cyc;

      // Continuous run with a freeze, halt on enabled cycle 57, full dump.
      do_reset();
      run_to_halt(57, 20);
      chk("cont_ciclos", 96'(o_ciclos), 96'(57));
      chk("cont_pipe_off", 96'(o_pipe_en), 96'(0));
      chk("cont_halt", 96'(o_halt), 96'(1));
      dump_all(-1, 0);
      repeat (4) tick();
      chk("done_sticky", 96'({o_done, o_pipe_en, o_ciclos}), 96'({1'b1, 1'b0, 32'd57}));

      // Single-cycle steps, one request held high for 10 cycles.
      do_reset();
      i_exec_mode  = 1'b1;
      i_step_count = CNT_BITS'(1);
      i_valid      = 1'b1;
      mon_clr      = 1'b1;
      tick();
      mon_clr      = 1'b0;
      repeat (4) tick();
      chk("step_wait_idle", 96'(o_pipe_en), 96'(0));
      i_step = 1'b1; tick(); i_step = 1'b0; repeat (5) tick();
      i_step = 1'b1; repeat (10) tick(); i_step = 1'b0; repeat (5) tick();
      i_step = 1'b1; tick(); i_step = 1'b0; repeat (5) tick();
      chk("step1_ciclos", 96'(o_ciclos), 96'(3));
      chk("step1_en_cycles", 96'(en_cnt), 96'(3));
      chk("step1_pulses", 96'(pulse_cnt), 96'(3));
      i_step_count = CNT_BITS'(0);
      i_step = 1'b1; tick(); i_step = 1'b0; repeat (5) tick();
      chk("step0_ciclos", 96'(o_ciclos), 96'(4));
      chk("step0_en_cycles", 96'(en_cnt), 96'(4));

      // Four-cycle step halted on its second cycle, then dump with backpressure at reg 7.
      do_reset();
      i_exec_mode  = 1'b1;
      i_step_count = CNT_BITS'(4);
      i_valid      = 1'b1;
      mon_clr      = 1'b1;
      tick();
      mon_clr      = 1'b0;
      repeat (2) tick();
      i_step = 1'b1; tick(); i_step = 1'b0;
      cyc = 0;
      while (!o_pipe_en && cyc < 20) begin tick(); cyc++; end
      chk("step4_start", 96'(o_pipe_en), 96'(1));
      tick();
      chk("step4_second", 96'(o_pipe_en), 96'(1));
      i_halt = 1'b1;
      tick();
      i_halt = 1'b0;
      chk("step4_ciclos", 96'(o_ciclos), 96'(2));
      chk("step4_pipe_off", 96'(o_pipe_en), 96'(0));
      chk("step4_halt", 96'(o_halt), 96'(1));
      repeat (3) tick();
      chk("step4_no_third", 96'(en_cnt), 96'(2));
      chk("step4_dump_reg", 96'({o_dump_sel, o_dump_valid, o_n_reg}), 96'({1'b0, 1'b1, 5'd0}));
      dump_all(7, 5);

      // Reset asserted mid memory dump, then a clean rerun.
      do_reset();
      run_to_halt(10, -1);
      i_dump_ready = 1'b1;
      cyc = 0;
      while (!(o_dump_sel && o_dump_valid && o_mem_addr == 6'd20) && cyc < 500) begin
         tick();
         cyc++;
      end
      chk("reach_addr20", 96'({o_dump_sel, o_mem_addr}), 96'({1'b1, 6'd20}));
      #2;
      i_reset = 1'b1;
      #1;
      chk("async_reset", 96'({o_pipe_en, o_ciclos, o_halt, o_dump_sel, o_n_reg, o_mem_addr,
                              o_dump_data, o_dump_valid, o_done}), 96'(0));
      do_reset();
      run_to_halt(5, -1);
      chk("rerun_ciclos", 96'(o_ciclos), 96'(5));
      dump_all(-1, 0);

`ifdef DEBUG_BREAKPOINT_EN
      // Breakpoint at PC 0x10 (PC = 4*ciclos), resumed by a step edge.
      do_reset();
      i_bp_addr   = 32'h10;
      i_bp_en     = 1'b1;
      i_exec_mode = 1'b0;
      i_valid     = 1'b1;
      cyc = 0;
      while (!o_bp_hit && cyc < 50) begin tick(); cyc++; end
      chk("bp_hit", 96'(o_bp_hit), 96'(1));
      chk("bp_paused", 96'(o_pipe_en), 96'(0));
      chk("bp_ciclos", 96'(o_ciclos), 96'(5));
      i_exec_mode = 1'b1;
      tick();
      chk("bp_hit_pulse", 96'(o_bp_hit), 96'(0));
      i_step = 1'b1;
      tick();
      i_step = 1'b0;
      chk("bp_resume", 96'(o_pipe_en), 96'(1));
      tick();
      chk("bp_resume_ciclos", 96'(o_ciclos), 96'(6));

      // Halt in the same cycle as the breakpoint match wins.
      do_reset();
      i_bp_addr   = 32'h10;
      i_bp_en     = 1'b1;
      i_exec_mode = 1'b0;
      i_valid     = 1'b1;
      cyc = 0;
      while (!(o_pipe_en && o_ciclos == 32'd4) && cyc < 50) begin tick(); cyc++; end
      i_halt = 1'b1;
      tick();
      i_halt = 1'b0;
      chk("bp_halt_no_hit", 96'({o_bp_hit, o_halt}), 96'({1'b0, 1'b1}));
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
      $finish;
   end

endmodule
